// File: rtl/zap_wb_arbiter_if.sv
// Bundle of the shared Wishbone signals around the arbiter.
// The slave modport is the arbiter's own view: it is the slave of the cache tops
// and drives the SoC bus. The master modport is the opposite side (cache tops and
// SoC slave together), which is how a testbench or wrapper connects to it.
interface zap_wb_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    // Per-master request side.
    logic [NUM_MASTERS-1:0]    i_wb_cyc;
    logic [NUM_MASTERS-1:0]    i_wb_stb;
    logic [NUM_MASTERS-1:0]    i_wb_wen;
    logic [4*NUM_MASTERS-1:0]  i_wb_sel;
    logic [32*NUM_MASTERS-1:0] i_wb_adr;
    logic [32*NUM_MASTERS-1:0] i_wb_dat;
    logic [3*NUM_MASTERS-1:0]  i_wb_cti;
    logic [NUM_MASTERS-1:0]    o_wb_ack;
    logic [NUM_MASTERS-1:0]    o_wb_err;
    logic [31:0]               o_wb_dat;

    // Shared slave side.
    logic                      o_wb_cyc;
    logic                      o_wb_stb;
    logic                      o_wb_wen;
    logic [3:0]                o_wb_sel;
    logic [31:0]               o_wb_adr;
    logic [31:0]               o_wb_dat_s;
    logic [2:0]                o_wb_cti;
    logic                      i_wb_ack_s;
    logic [31:0]               i_wb_dat_s;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat, i_wb_cti,
        output o_wb_ack, o_wb_err, o_wb_dat,
        output o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_adr, o_wb_dat_s, o_wb_cti,
        input  i_wb_ack_s, i_wb_dat_s
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat, i_wb_cti,
        input  o_wb_ack, o_wb_err, o_wb_dat,
        input  o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_adr, o_wb_dat_s, o_wb_cti,
        output i_wb_ack_s, i_wb_dat_s
    );
endinterface

// File: rtl/zap_wb_arbiter.sv
// Round-robin Wishbone B3 arbiter. Ownership is held for the whole cyc so bursts
// are never split; a watchdog kills strobes that a dead slave never acknowledges.
// The interface instance connected to bus must use the same NUM_MASTERS.
module zap_wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    zap_wb_arbiter_if.slave        bus,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic                   o_busy
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [2:0] CTI_EOB = 3'b111;

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [CW-1:0]   wd_count_reg, wd_count_next;

    // Per-master views of the packed request vectors.
    logic            cyc_m [NUM_MASTERS];
    logic            stb_m [NUM_MASTERS];
    logic            wen_m [NUM_MASTERS];
    logic [3:0]      sel_m [NUM_MASTERS];
    logic [31:0]     adr_m [NUM_MASTERS];
    logic [31:0]     dat_m [NUM_MASTERS];
    logic [2:0]      cti_m [NUM_MASTERS];

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_split
            assign cyc_m[gi] = bus.i_wb_cyc[gi];
            assign stb_m[gi] = bus.i_wb_stb[gi];
            assign wen_m[gi] = bus.i_wb_wen[gi];
            assign sel_m[gi] = bus.i_wb_sel[4*gi +: 4];
            assign adr_m[gi] = bus.i_wb_adr[32*gi +: 32];
            assign dat_m[gi] = bus.i_wb_dat[32*gi +: 32];
            assign cti_m[gi] = bus.i_wb_cti[3*gi +: 3];
        end
    endgenerate

    // First requester at or after start, wrapping modulo NUM_MASTERS.
    // Result is {found, index}.
    function automatic logic [IW:0] pick_first(input logic [NUM_MASTERS-1:0] req,
                                               input logic [IW-1:0] start);
        logic          found;
        logic [IW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            j = (int'(start) + i) % NUM_MASTERS;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        return {found, idx};
    endfunction

    logic          owned;
    logic          own_cyc, own_stb;
    logic [IW-1:0] after_owner;
    logic [IW-1:0] search_start;
    logic [IW:0]   pick_res;
    logic          stalled;
    logic          timeout_hit;

    assign owned        = (state_reg == OWN);
    assign own_cyc      = cyc_m[owner_reg];
    assign own_stb      = stb_m[owner_reg];
    assign after_owner  = (int'(owner_reg) == NUM_MASTERS - 1) ? '0 : owner_reg + 1'b1;
    // On release the search begins past the old owner, so it re-competes last.
    assign search_start = owned ? after_owner : ptr_reg;
    assign pick_res     = pick_first(bus.i_wb_cyc, search_start);
    assign stalled      = owned && own_cyc && own_stb && !bus.i_wb_ack_s;
    assign timeout_hit  = WD_EN && stalled && (wd_count_reg == WD_LAST);

    // State, owner, round-robin pointer and watchdog registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            ptr_reg      <= '0;
            wd_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            ptr_reg      <= ptr_next;
            wd_count_reg <= wd_count_next;
        end
    end

    // Arbitration, release and watchdog next-state logic.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        ptr_next      = ptr_reg;
        wd_count_next = '0;
        case (state_reg)
            IDLE: begin
                if (pick_res[IW]) begin
                    state_next = OWN;
                    owner_next = pick_res[IW-1:0];
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    // Owner finished its cycle: hand over directly if anyone waits.
                    ptr_next = after_owner;
                    if (pick_res[IW]) begin
                        owner_next = pick_res[IW-1:0];
                    end else begin
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    ptr_next   = after_owner;
                    state_next = IDLE;
                end else if (stalled) begin
                    wd_count_next = wd_count_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus mux: granted master drives the slave, idle bus parks at EOB.
    always_comb begin
        bus.o_wb_cyc   = 1'b0;
        bus.o_wb_stb   = 1'b0;
        bus.o_wb_wen   = 1'b0;
        bus.o_wb_sel   = 4'h0;
        bus.o_wb_adr   = 32'h0;
        bus.o_wb_dat_s = 32'h0;
        bus.o_wb_cti   = CTI_EOB;
        bus.o_wb_dat   = 32'h0;
        bus.o_wb_ack   = '0;
        bus.o_wb_err   = '0;
        if (owned) begin
            // A timed-out strobe is withdrawn in the same cycle the error is raised.
            bus.o_wb_cyc   = own_cyc && !timeout_hit;
            bus.o_wb_stb   = own_stb && !timeout_hit;
            bus.o_wb_wen   = wen_m[owner_reg];
            bus.o_wb_sel   = sel_m[owner_reg];
            bus.o_wb_adr   = adr_m[owner_reg];
            bus.o_wb_dat_s = dat_m[owner_reg];
            bus.o_wb_cti   = cti_m[owner_reg];
            bus.o_wb_dat   = bus.i_wb_dat_s;
            bus.o_wb_ack   = NUM_MASTERS'(bus.i_wb_ack_s) << owner_reg;
            bus.o_wb_err   = NUM_MASTERS'(timeout_hit) << owner_reg;
        end
    end

    assign o_grant = owned ? (NUM_MASTERS'(1) << owner_reg) : '0;
    assign o_busy  = owned;

endmodule

// File: doc/zap_wb_arbiter.md
Name: zap_wb_arbiter

Overview:
- Round-robin Wishbone B3 arbiter that shares one external bus between NUM_MASTERS cache/MMU subsystems (e.g. instruction cache and data cache tops).
- Ownership is locked for a whole cycle (i_wb_cyc high), so bursts (CTI_INCR … CTI_EOB) are never split.
- A bus watchdog terminates stalled strobes with an error so a dead slave cannot hang the core.
- Sits between the cache tops and the SoC bus.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- TIMEOUT, 1023, cycles of unacknowledged o_wb_stb before forced termination; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_cyc  in  NUM_MASTERS  per-master cyc.
- i_wb_stb  in  NUM_MASTERS  per-master stb.
- i_wb_wen  in  NUM_MASTERS  per-master write enable.
- i_wb_sel  in  4*NUM_MASTERS  per-master byte selects; master k at [4k+3:4k].
- i_wb_adr  in  32*NUM_MASTERS  per-master address.
- i_wb_dat  in  32*NUM_MASTERS  per-master write data.
- i_wb_cti  in  3*NUM_MASTERS  per-master cycle type.
- o_wb_ack  out  NUM_MASTERS  per-master ack.
- o_wb_err  out  NUM_MASTERS  per-master watchdog error.
- o_wb_dat  out  32  read data broadcast to all masters.
- o_wb_cyc, o_wb_stb, o_wb_wen  out  1 each  to slave.
- o_wb_sel  out  4  to slave.
- o_wb_adr  out  32  to slave.
- o_wb_dat_s  out  32  write data to slave.
- o_wb_cti  out  3  to slave.
- i_wb_ack_s  in  1  slave ack.
- i_wb_dat_s  in  32  slave read data.
- o_grant  out  NUM_MASTERS  one-hot current owner; 0 when idle.
- o_busy  out  1  bus owned.

Behaviour:
- Reset values:
  - state IDLE, o_grant=0, priority pointer=0, watchdog count=0.
  - All slave-side outputs 0 except o_wb_cti=CTI_EOB (3'b111).
  - o_wb_ack=0, o_wb_err=0, o_busy=0.
- States: IDLE, OWN.
- IDLE:
  - If any i_wb_cyc bit is set, register the grant to the first requester at or after the pointer (modulo NUM_MASTERS) and go to OWN.
  - Grant takes effect the next cycle: one cycle of arbitration latency.
- OWN:
  - Slave outputs are a combinational mux of the granted master's signals.
  - o_wb_dat mirrors i_wb_dat_s.
  - o_wb_ack[g]=i_wb_ack_s; ack bits of all other masters are 0.
- Release:
  - When the owner's i_wb_cyc is sampled 0, set pointer=(g+1) mod NUM_MASTERS.
  - If another master requests in that same cycle, grant it directly (OWN→OWN, no idle bubble); otherwise go to IDLE.
  - Ownership is never revoked while the owner's cyc=1, regardless of other requests or CTI.
- Idle outputs: in IDLE, o_wb_cyc=o_wb_stb=0, o_wb_cti=CTI_EOB, and all other slave outputs hold 0.
- Watchdog:
  - Counts cycles where o_wb_stb=1 and i_wb_ack_s=0; clears on ack or when stb=0.
  - On reaching TIMEOUT: assert o_wb_err[g] for 1 cycle, force o_wb_cyc=o_wb_stb=0 to the slave for that cycle, release the grant, go to IDLE, clear the count.
  - The owner must drop cyc on err. A late slave ack after timeout is ignored, i.e. not routed.
- Simultaneous events:
  - Ack arriving on the timeout cycle: ack wins and no err is raised.
  - Request and release by the same master in one cycle: it is treated as released, the pointer advances, and it re-competes.
- Reset mid-cycle: outputs return to reset values the next edge. No ack/err is generated to the interrupted master.
- o_busy=1 iff state=OWN.

Test Plan:
- Single master 0, 4-beat burst (CTI 010,010,010,111), slave acks every cycle → o_grant=01 from cycle after cyc rises; 4 acks only on o_wb_ack[0]; o_wb_ack[1]=0 throughout.
- Both masters assert cyc same cycle after reset → master 0 granted first. On its release, master 1 granted with no idle cycle. Pointer then 0; next contention grants 0.
- Master 1 requests during master 0 burst at beat 2 → master 0 completes all 4 beats uninterrupted; master 1 granted the cycle after master 0 cyc=0.
- TIMEOUT=8, slave never acks master 1 single read → o_wb_err[1]=1 on the 8th stalled cycle; o_wb_stb=0 next cycle; state IDLE; o_wb_ack=00.
- Ack on exactly the TIMEOUT cycle → o_wb_ack[g]=1, o_wb_err=00, ownership retained.
- i_reset asserted mid-burst → next cycle o_grant=0, o_wb_cyc=0, o_wb_cti=111, no ack/err pulses.
